// File: rtl/mem_loader.sv
// mem_loader: boot loader that assembles a length-prefixed byte stream into 16-bit
// words, writes them to memory from address 0 and holds the CPU until done.
module mem_loader #(
  parameter int unsigned MEM_SIZE = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] t_reg,
  output logic [15:0] write_val,
  output logic        write,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, DONE, ERROR} state_t;
  state_t      state;
  logic [15:0] len;
  logic [7:0]  lo;
  logic [31:0] hdr;
  assign hdr = {16'd0, in_data, len[7:0]};
  // in_ready is high exactly in the four byte-consuming states, so in_valid alone marks a handshake there
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      write        <= 1'b0;
      t_reg        <= '0;
      write_val    <= '0;
      words_loaded <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_hold     <= 1'b1;
      len          <= '0;
      lo           <= '0;
    end else begin
      write <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: if (start) begin
          state        <= LEN_LO;
          in_ready     <= 1'b1;
          done         <= 1'b0;
          error        <= 1'b0;
          words_loaded <= '0;
          cpu_hold     <= 1'b1;
        end
        LEN_LO: if (in_valid) begin
          len[7:0] <= in_data;
          state    <= LEN_HI;
        end
        LEN_HI: if (in_valid) begin
          len[15:8] <= in_data;
          if (hdr == 32'd0) begin
            state    <= DONE;
            in_ready <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else if (hdr > MEM_SIZE) begin
            state    <= ERROR;
            in_ready <= 1'b0;
            error    <= 1'b1;
          end else begin
            state <= DATA_LO;
          end
        end
        DATA_LO: if (in_valid) begin
          lo    <= in_data;
          state <= DATA_HI;
        end
        DATA_HI: if (in_valid) begin
          write        <= 1'b1;
          write_val    <= {in_data, lo};
          t_reg        <= words_loaded;
          words_loaded <= words_loaded + 16'd1;
          if (words_loaded == len - 16'd1) begin
            state    <= DONE;
            in_ready <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state <= DATA_LO;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed streams checked against a stream-position model every cycle
// plus literal expectations on the write log and final status.
module tb_mem_loader;
  logic        clk = 0, rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, write, cpu_hold, done, error;
  logic [15:0] t_reg, write_val, words_loaded;
  int checks = 0, failures = 0;
  localparam int MSZ = 16;

  mem_loader #(.MEM_SIZE(MSZ)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .t_reg(t_reg), .write_val(write_val), .write(write),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int data; int cyc;} wr_t;
  wr_t wq[$];
  int  cyc = 0, hs = 0;
  bit  armed = 0;
  // model: loading flag, bytes consumed in this load, header count, pending low byte
  bit  m_ready, m_write, m_done, m_error, m_hold;
  int  m_addr, m_data, m_words, nb, n, lo;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (in_valid && in_ready) hs++;
    if (rst) begin
      m_ready = 0; m_write = 0; m_addr = 0; m_data = 0; m_words = 0;
      m_done = 0; m_error = 0; m_hold = 1; nb = 0; armed = 1;
    end else begin
      m_write = 0;
      if (!m_ready) begin
        if (start) begin
          m_ready = 1; m_done = 0; m_error = 0; m_words = 0; m_hold = 1; nb = 0;
        end
      end else if (in_valid) begin
        if (nb == 0) n = int'(in_data);
        else if (nb == 1) begin
          n = n + 256 * int'(in_data);
          if (n == 0) begin m_ready = 0; m_done = 1; m_hold = 0; end
          else if (n > MSZ) begin m_ready = 0; m_error = 1; end
        end else if (nb % 2 == 0) lo = int'(in_data);
        else begin
          m_write = 1; m_addr = m_words; m_data = 256 * int'(in_data) + lo; m_words++;
          if (m_words == n) begin m_ready = 0; m_done = 1; m_hold = 0; end
        end
        nb++;
      end
    end
  end

  always @(negedge clk) if (armed) begin
    chk("in_ready", int'(in_ready), int'(m_ready));
    chk("write", int'(write), int'(m_write));
    chk("t_reg", int'(t_reg), m_addr);
    chk("write_val", int'(write_val), m_data);
    chk("words_loaded", int'(words_loaded), m_words);
    chk("done", int'(done), int'(m_done));
    chk("error", int'(error), int'(m_error));
    chk("cpu_hold", int'(cpu_hold), int'(m_hold));
    if (write) wq.push_back('{int'(t_reg), int'(write_val), cyc});
  end

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    in_valid = 0;
    repeat (gap) @(negedge clk);
    in_data = b;
    in_valid = 1;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    if (t == 20) chk("ready_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    in_valid = 0;
    repeat (k) @(negedge clk);
  endtask

  task automatic chk_log(input string nm, input int idx, input int a, input int d);
    if (wq.size() > idx) begin
      chk({nm, "_addr"}, wq[idx].addr, a);
      chk({nm, "_data"}, wq[idx].data, d);
    end else chk({nm, "_missing"}, wq.size(), idx + 1);
  endtask

  initial begin
    logic [7:0] basic [6] = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB};
    rst = 1; start = 0; in_valid = 0; in_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_cpu_hold", int'(cpu_hold), 1);
    chk("rst_done", int'(done), 0);
    rst = 0;
    idle(2);

    // basic back-to-back load
    wq.delete();
    pulse_start();
    foreach (basic[i]) send(basic[i], 0);
    idle(3);
    chk("basic_nwr", wq.size(), 2);
    chk_log("basic0", 0, 0, 16'h1234);
    chk_log("basic1", 1, 1, 16'hABCD);
    if (wq.size() == 2) chk("basic_spacing", wq[1].cyc - wq[0].cyc, 2);
    chk("basic_done", int'(done), 1);
    chk("basic_hold", int'(cpu_hold), 0);
    chk("basic_words", int'(words_loaded), 2);

    // zero length
    wq.delete();
    pulse_start();
    send(8'h00, 0);
    send(8'h00, 0);
    chk("zero_done", int'(done), 1);
    chk("zero_hold", int'(cpu_hold), 0);
    idle(2);
    chk("zero_nwr", wq.size(), 0);

    // oversize header, then recover
    wq.delete();
    pulse_start();
    send(8'h11, 0);
    send(8'h00, 0);
    idle(2);
    chk("ovr_error", int'(error), 1);
    chk("ovr_hold", int'(cpu_hold), 1);
    chk("ovr_ready", int'(in_ready), 0);
    chk("ovr_nwr", wq.size(), 0);
    pulse_start();
    chk("ovr_clr_error", int'(error), 0);
    chk("ovr_relen_ready", int'(in_ready), 1);
    send(8'h00, 0);
    send(8'h00, 0);
    idle(2);

    // stalled load with random gaps
    wq.delete();
    pulse_start();
    hs = 0;
    foreach (basic[i]) send(basic[i], (i == 5) ? 4 : int'($urandom_range(0, 3)));
    idle(3);
    chk("stall_hs", hs, 6);
    chk("stall_nwr", wq.size(), 2);
    chk_log("stall0", 0, 0, 16'h1234);
    chk_log("stall1", 1, 1, 16'hABCD);
    chk("stall_done", int'(done), 1);

    // reset mid-word, then start ignored mid-load
    wq.delete();
    pulse_start();
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'hEF, 0);
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    idle(2);
    chk("mid_nwr", wq.size(), 0);
    chk("mid_ready", int'(in_ready), 0);
    chk("mid_hold", int'(cpu_hold), 1);
    chk("mid_words", int'(words_loaded), 0);
    pulse_start();
    send(8'h01, 0);
    send(8'h00, 0);
    idle(1);
    pulse_start();
    send(8'h22, 0);
    send(8'h11, 0);
    idle(2);
    chk("fresh_nwr", wq.size(), 1);
    chk_log("fresh", 0, 0, 16'h1122);
    chk("fresh_done", int'(done), 1);

    // reload
    wq.delete();
    pulse_start();
    send(8'h01, 0); send(8'h00, 0); send(8'h55, 0); send(8'h55, 0);
    idle(2);
    chk("rl1_done", int'(done), 1);
    pulse_start();
    chk("rl_done_clr", int'(done), 0);
    chk("rl_hold", int'(cpu_hold), 1);
    send(8'h01, 0); send(8'h00, 0); send(8'h77, 0); send(8'h77, 0);
    idle(2);
    chk("rl_nwr", wq.size(), 2);
    chk_log("rl2", 1, 0, 16'h7777);
    chk("rl2_done", int'(done), 1);
    chk("rl2_hold", int'(cpu_hold), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
